// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU rounding-mode encodings and default widths
package fpu_pkg;
    localparam logic [2:0] FRM_RNE = 3'b000;
    localparam logic [2:0] FRM_RTZ = 3'b001;
    localparam logic [2:0] FRM_RDN = 3'b010;
    localparam logic [2:0] FRM_RUP = 3'b011;
    localparam logic [2:0] FRM_RMM = 3'b100;
    localparam logic [2:0] FRM_DYN = 3'b111;

    localparam int SIG_BITS_DEF = 32;
    localparam int FRA_BITS_DEF = 23;
    localparam int EXP_BITS_DEF = 8;
    localparam int FRM_BITS_DEF = 3;

    function automatic logic frm_is_legal(input logic [2:0] frm);
        return frm <= FRM_RMM;
    endfunction
endpackage

// File: rtl/round.sv
// rtl/round.sv - combinational significand rounding to FRA_BITS+1 kept bits
module round
    import fpu_pkg::*;
#(
    parameter int SIG_BITS = SIG_BITS_DEF,
    parameter int FRA_BITS = FRA_BITS_DEF,
    parameter int EXP_BITS = EXP_BITS_DEF,
    parameter int FRM_BITS = FRM_BITS_DEF
) (
    input  logic [SIG_BITS-1:0] i_sig,
    input  logic [EXP_BITS-1:0] i_exp,
    input  logic                i_sign,
    input  logic [FRM_BITS-1:0] i_frm,
    output logic [SIG_BITS-1:0] o_sig,
    output logic [EXP_BITS-1:0] o_exp,
    output logic                o_nx,
    output logic                o_of,
    output logic                o_illegal
);
    localparam int KEEP = FRA_BITS + 1;
    localparam int DROP = SIG_BITS - KEEP;

    logic [KEEP-1:0] w_kept;
    logic [KEEP:0]   w_sum;
    logic            w_lsb, w_rnd, w_stk, w_inc, w_legal;

    assign w_kept  = i_sig[SIG_BITS-1 -: KEEP];
    assign w_lsb   = i_sig[DROP];
    assign w_rnd   = i_sig[DROP-1];
    assign w_stk   = |i_sig[DROP-2:0];
    assign w_legal = frm_is_legal(i_frm);

    always_comb begin
        case (i_frm)
            FRM_RNE: w_inc = w_rnd & (w_stk | w_lsb);
            FRM_RDN: w_inc = i_sign & (w_rnd | w_stk);
            FRM_RUP: w_inc = ~i_sign & (w_rnd | w_stk);
            FRM_RMM: w_inc = w_rnd;
            default: w_inc = 1'b0;
        endcase
    end

    // The extra MSB of the sum is the carry out of an all-ones kept field.
    assign w_sum     = {1'b0, w_kept} + {{KEEP{1'b0}}, w_inc};
    assign o_of      = w_legal & w_sum[KEEP];
    assign o_nx      = w_legal & (w_rnd | w_stk);
    assign o_illegal = ~w_legal;

    always_comb begin
        o_sig = i_sig;
        o_exp = i_exp;
        if (w_legal) begin
            if (w_sum[KEEP]) begin
                o_sig = {1'b1, {(SIG_BITS-1){1'b0}}};
                o_exp = i_exp + EXP_BITS'(1);
            end else begin
                o_sig = {w_sum[KEEP-1:0], {DROP{1'b0}}};
            end
        end
    end
endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant search starting at a rotating pointer
module rr_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int TAG_BITS = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  i_valid,
    input  logic [TAG_BITS-1:0] i_ptr,
    input  logic                i_en,
    output logic [NUM_REQ-1:0]  o_grant,
    output logic [TAG_BITS-1:0] o_idx,
    output logic                o_any
);
    int w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = (int'(i_ptr) + k) % NUM_REQ;
            if (!o_any && i_en && i_valid[w_j]) begin
                o_any        = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = TAG_BITS'(w_j);
            end
        end
    end
endmodule

// File: rtl/fpu_round_sched.sv
// rtl/fpu_round_sched.sv - shares one rounding unit among NUM_REQ producers
module fpu_round_sched
    import fpu_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int SIG_BITS = SIG_BITS_DEF,
    parameter int FRA_BITS = FRA_BITS_DEF,
    parameter int EXP_BITS = EXP_BITS_DEF,
    parameter int FRM_BITS = FRM_BITS_DEF,
    parameter int TAG_BITS = $clog2(NUM_REQ)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_REQ-1:0]           i_req_valid,
    output logic [NUM_REQ-1:0]           o_req_ready,
    input  logic [NUM_REQ*SIG_BITS-1:0]  i_req_sig,
    input  logic [NUM_REQ*EXP_BITS-1:0]  i_req_exp,
    input  logic [NUM_REQ-1:0]           i_req_sign,
    input  logic [NUM_REQ*FRM_BITS-1:0]  i_req_frm,
    input  logic [FRM_BITS-1:0]          i_csr_frm,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [SIG_BITS-1:0]          o_out_sig,
    output logic [EXP_BITS-1:0]          o_out_exp,
    output logic [TAG_BITS-1:0]          o_out_tag,
    output logic                         o_out_nx,
    output logic                         o_out_of,
    output logic                         o_out_illegal
);
    logic [TAG_BITS-1:0] r_rr_ptr;
    logic                r_out_valid;
    logic [SIG_BITS-1:0] r_sig;
    logic [EXP_BITS-1:0] r_exp;
    logic [TAG_BITS-1:0] r_tag;
    logic                r_nx, r_of, r_illegal;

    logic                w_can_accept, w_any;
    logic [NUM_REQ-1:0]  w_grant;
    logic [TAG_BITS-1:0] w_idx;
    logic [SIG_BITS-1:0] w_sig, w_rsig;
    logic [EXP_BITS-1:0] w_exp, w_rexp;
    logic [FRM_BITS-1:0] w_frm, w_eff_frm;
    logic                w_sign, w_nx, w_of, w_illegal;

    assign w_can_accept = !r_out_valid || i_out_ready;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .TAG_BITS(TAG_BITS)) u_arb (
        .i_valid (i_req_valid),
        .i_ptr   (r_rr_ptr),
        .i_en    (w_can_accept),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_sig     = i_req_sig[int'(w_idx)*SIG_BITS +: SIG_BITS];
    assign w_exp     = i_req_exp[int'(w_idx)*EXP_BITS +: EXP_BITS];
    assign w_frm     = i_req_frm[int'(w_idx)*FRM_BITS +: FRM_BITS];
    assign w_sign    = i_req_sign[w_idx];
    assign w_eff_frm = (w_frm == FRM_BITS'(FRM_DYN)) ? i_csr_frm : w_frm;

    round #(
        .SIG_BITS(SIG_BITS), .FRA_BITS(FRA_BITS),
        .EXP_BITS(EXP_BITS), .FRM_BITS(FRM_BITS)
    ) u_round (
        .i_sig     (w_sig),
        .i_exp     (w_exp),
        .i_sign    (w_sign),
        .i_frm     (w_eff_frm),
        .o_sig     (w_rsig),
        .o_exp     (w_rexp),
        .o_nx      (w_nx),
        .o_of      (w_of),
        .o_illegal (w_illegal)
    );

    // Data fields only change on a transfer; draining clears valid alone.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_sig       <= '0;
            r_exp       <= '0;
            r_tag       <= '0;
            r_nx        <= 1'b0;
            r_of        <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_any) begin
            r_rr_ptr    <= (w_idx == TAG_BITS'(NUM_REQ-1)) ? '0 : w_idx + TAG_BITS'(1);
            r_out_valid <= 1'b1;
            r_sig       <= w_rsig;
            r_exp       <= w_rexp;
            r_tag       <= w_idx;
            r_nx        <= w_nx;
            r_of        <= w_of;
            r_illegal   <= w_illegal;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_req_ready   = w_grant;
    assign o_out_valid   = r_out_valid;
    assign o_out_sig     = r_sig;
    assign o_out_exp     = r_exp;
    assign o_out_tag     = r_tag;
    assign o_out_nx      = r_nx;
    assign o_out_of      = r_of;
    assign o_out_illegal = r_illegal;
endmodule

// File: tb/tb_fpu_round_sched.sv
// tb/tb_fpu_round_sched.sv - self-checking bench for fpu_round_sched
module tb_fpu_round_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [95:0] req_sig;
    logic [23:0] req_exp;
    logic [2:0]  req_sign;
    logic [8:0]  req_frm;
    logic [2:0]  csr_frm;
    logic        out_valid, out_ready;
    logic [31:0] out_sig;
    logic [7:0]  out_exp;
    logic [1:0]  out_tag;
    logic        out_nx, out_of, out_illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] sig;
        logic [7:0]  e;
        logic        nx;
        logic        of;
        logic        ill;
    } res_t;

    res_t        m_res;
    logic        m_valid;
    logic [1:0]  m_tag;
    int          m_ptr;

    always #5 clk = ~clk;

    fpu_round_sched dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_sig(req_sig), .i_req_exp(req_exp), .i_req_sign(req_sign),
        .i_req_frm(req_frm), .i_csr_frm(csr_frm),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_sig(out_sig), .o_out_exp(out_exp), .o_out_tag(out_tag),
        .o_out_nx(out_nx), .o_out_of(out_of), .o_out_illegal(out_illegal)
    );

    // Value-level rounding: keep sig/256, decide from the discarded byte.
    function automatic res_t ref_round(input logic [31:0] sig, input logic [7:0] e,
                                       input logic sign, input logic [2:0] frm,
                                       input logic [2:0] csr);
        res_t r;
        int unsigned kept, rem;
        bit inc;
        logic [2:0] m;
        m    = (frm == 3'd7) ? csr : frm;
        kept = sig / 256;
        rem  = sig % 256;
        r.sig = sig; r.e = e; r.nx = 0; r.of = 0; r.ill = 0;
        if (m > 3'd4) begin
            r.ill = 1;
            return r;
        end
        case (m)
            3'd0:    inc = (rem > 128) || (rem == 128 && (kept % 2) == 1);
            3'd2:    inc = sign && rem != 0;
            3'd3:    inc = !sign && rem != 0;
            3'd4:    inc = rem >= 128;
            default: inc = 0;
        endcase
        r.nx = rem != 0;
        kept = kept + (inc ? 1 : 0);
        if (kept == (1 << 24)) begin
            r.sig = 32'h8000_0000;
            r.e   = e + 8'd1;
            r.of  = 1;
        end else begin
            r.sig = kept * 256;
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] s, input logic [7:0] e,
                           input logic sg, input logic [2:0] f);
        req_sig[i*32 +: 32] = s;
        req_exp[i*8 +: 8]   = e;
        req_sign[i]         = sg;
        req_frm[i*3 +: 3]   = f;
    endtask

    task automatic do_reset;
        rst_n = 0; req_valid = 0; out_ready = 0;
        repeat (2) tick;
        rst_n = 1;
        tick;
        m_valid = 0; m_ptr = 0; m_tag = 0;
        m_res.sig = 0; m_res.e = 0; m_res.nx = 0; m_res.of = 0; m_res.ill = 0;
    endtask

    task automatic test_reset;
        rst_n = 0; req_valid = 0; out_ready = 0; csr_frm = 0;
        req_sig = '0; req_exp = '0; req_sign = '0; req_frm = '0;
        repeat (2) tick;
        checks++;
        if ({out_valid, out_sig, out_exp, out_tag, out_nx, out_of, out_illegal, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b sig=%h exp=%h tag=%0d ready=%b, expected all zero",
                     out_valid, out_sig, out_exp, out_tag, req_ready);
        end
        rst_n = 1;
        tick;
    endtask

    task automatic test_directed;
        out_ready = 1;
        set_req(0, 32'h8000_0180, 8'h7F, 0, 3'b000);
        req_valid = 3'b001;
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++; $display("FAIL rne_grant: ready=%b expected 001", req_ready);
        end
        tick;
        req_valid = 0;
        checks++;
        if ({out_valid, out_sig, out_exp, out_nx, out_of, out_tag, out_illegal} !==
            {1'b1, 32'h8000_0200, 8'h7F, 1'b1, 1'b0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL rne_result: got v=%0b sig=%h exp=%h nx=%0b of=%0b tag=%0d ill=%0b expected 1 80000200 7f 1 0 0 0",
                     out_valid, out_sig, out_exp, out_nx, out_of, out_tag, out_illegal);
        end

        set_req(0, 32'hFFFF_FF80, 8'h80, 0, 3'b000);
        req_valid = 3'b001;
        tick;
        req_valid = 0;
        checks++;
        if ({out_sig, out_exp, out_of, out_nx} !== {32'h8000_0000, 8'h81, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL carry: got sig=%h exp=%h of=%0b nx=%0b expected 80000000 81 1 1",
                     out_sig, out_exp, out_of, out_nx);
        end

        csr_frm = 3'b001;
        set_req(0, 32'h8000_01FF, 8'h10, 0, 3'b111);
        req_valid = 3'b001;
        tick;
        checks++;
        if ({out_sig, out_nx, out_illegal} !== {32'h8000_0100, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL dyn_rtz: got sig=%h nx=%0b ill=%0b expected 80000100 1 0", out_sig, out_nx, out_illegal);
        end

        csr_frm = 3'b101;
        tick;
        req_valid = 0;
        checks++;
        if ({out_valid, out_illegal, out_sig, out_exp, out_nx, out_of} !==
            {1'b1, 1'b1, 32'h8000_01FF, 8'h10, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL dyn_illegal: got v=%0b ill=%0b sig=%h exp=%h nx=%0b of=%0b expected 1 1 800001ff 10 0 0",
                     out_valid, out_illegal, out_sig, out_exp, out_nx, out_of);
        end
        tick;
        checks++;
        if (out_valid !== 1'b0 || out_sig !== 32'h8000_01FF) begin
            errors++;
            $display("FAIL drain_hold: got v=%0b sig=%h expected 0 800001ff", out_valid, out_sig);
        end
        csr_frm = 0;
    endtask

    task automatic test_fairness;
        do_reset;
        for (int i = 0; i < 3; i++) set_req(i, 32'h1000_0000 * (i + 1), 8'(i), 0, 3'b001);
        out_ready = 1;
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (req_ready !== 3'(1 << (k % 3))) begin
                errors++; $display("FAIL fair_ready[%0d]: got %b expected %b", k, req_ready, 3'(1 << (k % 3)));
            end
            tick;
            checks++;
            if (out_valid !== 1'b1 || out_tag !== 2'(k % 3)) begin
                errors++; $display("FAIL fair_tag[%0d]: got v=%0b tag=%0d expected 1 %0d", k, out_valid, out_tag, k % 3);
            end
        end
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++; $display("FAIL fair_wrap: got %b expected 001", req_ready);
        end
        req_valid = 0;
        tick;
    endtask

    task automatic test_backpressure;
        res_t r0, r1, r2;
        do_reset;
        for (int i = 0; i < 3; i++) set_req(i, $urandom, 8'($urandom), 1'($urandom), 3'($urandom_range(0, 4)));
        r0 = ref_round(req_sig[31:0], req_exp[7:0], req_sign[0], req_frm[2:0], csr_frm);
        r1 = ref_round(req_sig[63:32], req_exp[15:8], req_sign[1], req_frm[5:3], csr_frm);
        r2 = ref_round(req_sig[95:64], req_exp[23:16], req_sign[2], req_frm[8:6], csr_frm);
        out_ready = 1;
        req_valid = 3'b001;
        tick;
        out_ready = 0;
        req_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (req_ready !== 3'b000) begin
                errors++; $display("FAIL bp_ready[%0d]: got %b expected 000", k, req_ready);
            end
            tick;
            checks++;
            if ({out_valid, out_tag, out_sig, out_exp, out_nx, out_of, out_illegal} !==
                {1'b1, 2'd0, r0.sig, r0.e, r0.nx, r0.of, r0.ill}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%0b tag=%0d sig=%h exp=%h expected 1 0 %h %h",
                         k, out_valid, out_tag, out_sig, out_exp, r0.sig, r0.e);
            end
        end
        out_ready = 1;
        #1;
        checks++;
        if (req_ready !== 3'b010) begin
            errors++; $display("FAIL bp_release_ready: got %b expected 010", req_ready);
        end
        tick;
        checks++;
        if ({out_valid, out_tag, out_sig, out_exp, out_nx, out_of, out_illegal} !==
            {1'b1, 2'd1, r1.sig, r1.e, r1.nx, r1.of, r1.ill}) begin
            errors++;
            $display("FAIL bp_release_result: got v=%0b tag=%0d sig=%h expected 1 1 %h", out_valid, out_tag, out_sig, r1.sig);
        end
        tick;
        req_valid = 0;
        checks++;
        if ({out_valid, out_tag, out_sig, out_exp} !== {1'b1, 2'd2, r2.sig, r2.e}) begin
            errors++;
            $display("FAIL bp_no_bubble: got v=%0b tag=%0d sig=%h expected 1 2 %h", out_valid, out_tag, out_sig, r2.sig);
        end
        tick;
    endtask

    task automatic test_async_reset;
        do_reset;
        set_req(1, 32'h4000_0000, 8'h01, 0, 3'b000);
        set_req(2, 32'h2000_0000, 8'h02, 0, 3'b000);
        req_valid = 3'b010;
        tick;
        req_valid = 0;
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sig !== 32'h0 || out_tag !== 2'd0) begin
            errors++; $display("FAIL async_reset: got v=%0b sig=%h tag=%0d expected 0 0 0", out_valid, out_sig, out_tag);
        end
        repeat (2) tick;
        rst_n = 1;
        repeat (2) tick;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_pulse: got v=%0b expected 0", out_valid);
        end
        req_valid = 3'b110;
        #1;
        checks++;
        if (req_ready !== 3'b010) begin
            errors++; $display("FAIL post_reset_grant: got %b expected 010", req_ready);
        end
        tick;
        req_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 2'd1 || out_sig !== 32'h4000_0000) begin
            errors++; $display("FAIL post_reset_result: got v=%0b tag=%0d sig=%h expected 1 1 40000000", out_valid, out_tag, out_sig);
        end
        tick;
    endtask

    task automatic test_random;
        logic [2:0] exp_ready;
        logic [31:0] s;
        int g;
        bit can;
        do_reset;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                s = $urandom;
                if ($urandom_range(0, 5) == 0) s[31:8] = '1;
                set_req(i, s, 8'($urandom), 1'($urandom), 3'($urandom));
            end
            csr_frm   = 3'($urandom);
            req_valid = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            can = !m_valid || out_ready;
            g = -1;
            for (int k = 0; k < 3; k++)
                if (g < 0 && can && req_valid[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
            exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
            #1;
            checks++;
            if (req_ready !== exp_ready) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", cyc, req_ready, exp_ready);
            end
            tick;
            if (g >= 0) begin
                m_res = ref_round(req_sig[g*32 +: 32], req_exp[g*8 +: 8], req_sign[g], req_frm[g*3 +: 3], csr_frm);
                m_valid = 1;
                m_tag = 2'(g);
                m_ptr = (g + 1) % 3;
            end else if (out_ready) begin
                m_valid = 0;
            end
            checks++;
            if ({out_valid, out_tag, out_sig, out_exp, out_nx, out_of, out_illegal} !==
                {m_valid, m_tag, m_res.sig, m_res.e, m_res.nx, m_res.of, m_res.ill}) begin
                errors++;
                $display("FAIL rand_out[%0d]: got v=%0b tag=%0d sig=%h exp=%h nx=%0b of=%0b ill=%0b expected %0b %0d %h %h %0b %0b %0b",
                         cyc, out_valid, out_tag, out_sig, out_exp, out_nx, out_of, out_illegal,
                         m_valid, m_tag, m_res.sig, m_res.e, m_res.nx, m_res.of, m_res.ill);
            end
        end
        req_valid = 0;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_fairness;
        test_backpressure;
        test_async_reset;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
